// File: rtl/apple_video_pkg.sv
// Shared types, constants and row-base address helpers for the Apple II
// per-scanline video fetch engine.
package apple_video_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    SWAP
  } fetch_state_t;

  localparam logic [15:0] TEXT_PAGE1_BASE  = 16'h0400;
  localparam logic [15:0] HIRES_PAGE1_BASE = 16'h2000;
  localparam int          WORDS_PER_LINE   = 20;
  localparam int          MIXED_TEXT_LINE  = 160;
  localparam int          VISIBLE_LINES    = 192;
  localparam int          DATA_W           = 32;
  localparam int          IDX_W            = 5;

  // Text rows are 8 scanlines tall; 24 rows interleaved in groups of 8.
  function automatic logic [15:0] text_row_base(input logic [7:0] line, input logic pg2);
    logic [4:0] row;
    row = line[7:3];
    return TEXT_PAGE1_BASE
         + {6'd0, row[2:0], 7'd0}
         + 16'(row[4:3]) * 16'h0028
         + (pg2 ? 16'h0400 : 16'h0000);
  endfunction

  // Hires interleave: line[2:0] selects a 1 KB block, [5:3] a 128-byte
  // group, [7:6] a 40-byte third.
  function automatic logic [15:0] hires_row_base(input logic [7:0] line, input logic pg2);
    return HIRES_PAGE1_BASE
         + {3'd0, line[2:0], 10'd0}
         + {6'd0, line[5:3], 7'd0}
         + 16'(line[7:6]) * 16'h0028
         + (pg2 ? 16'h2000 : 16'h0000);
  endfunction

endpackage

// File: rtl/video_line_buffer.sv
// Double-banked scanline buffer: one write port for the fetch engine,
// one registered read port for the renderer. Storage is not reset so it
// maps onto block RAM; only the read register is cleared.
module video_line_buffer #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(2 << IDX_W) - 1];

  // Write captured words into the selected bank.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  // Registered read, one cycle latency, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

// File: rtl/apple_video_fetch.sv
// Per-scanline fetch engine: computes the text/hires row base from the
// soft switches at line start, issues 20 word reads to the shadow video
// memory, captures the returned words into the back bank and swaps banks.
module apple_video_fetch (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic        line_start_i,
  input  logic [7:0]  line_i,
  input  logic        text_mode_i,
  input  logic        mixed_mode_i,
  input  logic        hires_mode_i,
  input  logic        page2_i,
  input  logic        store80_i,
  output logic [15:0] video_address_o,
  output logic        video_rd_o,
  input  logic [31:0] video_data_i,
  input  logic [4:0]  buf_rd_addr_i,
  output logic [31:0] buf_rd_data_o,
  output logic        line_is_text_o,
  output logic        busy_o,
  output logic        line_ready_o
);

  import apple_video_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  fetch_state_t     state;
  logic [IDX_W-1:0] k;
  logic             front;
  logic             pend_text;
  logic             start_ok;
  logic             is_text_new;
  logic             pg2;
  logic [15:0]      base_new;
  logic             cap_vld_p1;
  logic [IDX_W-1:0] cap_idx_p1;

  assign start_ok    = line_start_i && (line_i < 8'(VISIBLE_LINES));
  assign is_text_new = text_mode_i | (mixed_mode_i & (line_i >= 8'(MIXED_TEXT_LINE))) | ~hires_mode_i;
  assign pg2         = page2_i & ~store80_i;
  assign base_new    = is_text_new ? text_row_base(line_i, pg2) : hires_row_base(line_i, pg2);

  // Fetch sequencer. A legal start restarts from word 0 in any state; the
  // bank swap is performed on entry to SWAP so line_ready_o is registered.
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      state           <= IDLE;
      k               <= '0;
      video_rd_o      <= 1'b0;
      video_address_o <= 16'h0000;
      busy_o          <= 1'b0;
      line_ready_o    <= 1'b0;
      line_is_text_o  <= 1'b1;
      front           <= 1'b0;
      pend_text       <= 1'b1;
    end else begin
      line_ready_o <= 1'b0;
      if (start_ok) begin
        state           <= FETCH;
        k               <= '0;
        video_rd_o      <= 1'b1;
        video_address_o <= base_new;
        pend_text       <= is_text_new;
        busy_o          <= 1'b1;
      end else begin
        case (state)
          FETCH: begin
            if (k == LAST_IDX) begin
              video_rd_o <= 1'b0;
              state      <= DRAIN;
            end else begin
              k               <= k + 1'b1;
              video_address_o <= video_address_o + 16'd2;
            end
          end
          DRAIN: begin
            state          <= SWAP;
            front          <= ~front;
            line_is_text_o <= pend_text;
            line_ready_o   <= 1'b1;
          end
          SWAP: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            video_rd_o <= 1'b0;
            busy_o     <= 1'b0;
          end
        endcase
      end
    end
  end

  // Capture stage valid: read data returns one cycle after its address.
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      cap_vld_p1 <= 1'b0;
    end else begin
      cap_vld_p1 <= video_rd_o;
    end
  end

  // Capture stage index travels with the valid.
  always_ff @(posedge clk_logic) begin
    cap_idx_p1 <= k;
  end

  video_line_buffer #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_line_buffer (
    .clk     (clk_logic),
    .rst_n   (system_reset_n),
    .we      (cap_vld_p1),
    .wr_bank (~front),
    .wr_addr (cap_idx_p1),
    .wr_data (video_data_i),
    .rd_bank (front),
    .rd_addr (buf_rd_addr_i),
    .rd_data (buf_rd_data_o)
  );

endmodule
